// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: fetch, decode, execute, memory, write-back.
// All outputs are registered; strobes are set on entry to the state in which they are valid.
module multicycle_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instr_o,
  output logic [2:0]  imm_type_o,
  output logic        alu_src_a_o,
  output logic        alu_src_b_o,
  input  logic        branch_taken_in,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_ack_in,
  output logic        reg_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_src_o,
  output logic        illegal_o,
  output logic        bus_err_o,
  output logic [2:0]  state_o
);

  // Handshake: a request stays high until the cycle its ack is seen; an ack
  // sampled while the matching request is low has no effect.

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] IMM_R = 3'b000;
  localparam logic [2:0] IMM_I = 3'b001;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_J = 3'b101;
  localparam logic [2:0] IMM_S = 3'b110;

  localparam logic [16:0] TIMEOUT_LIMIT = 17'(ACK_TIMEOUT);

  state_t      state;
  logic [15:0] wait_cnt;
  logic [16:0] wait_next;
  logic        wait_expired;
  logic [6:0]  opcode;
  logic        rd_nonzero;

  logic is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, is_op, is_op_imm;
  logic is_legal;

  assign opcode       = instr_o[6:0];
  assign rd_nonzero   = (instr_o[11:7] != 5'd0);
  assign wait_next    = {1'b0, wait_cnt} + 17'd1;
  // This cycle is the last one allowed before a missing ack becomes a trap.
  assign wait_expired = (wait_next >= TIMEOUT_LIMIT);
  assign state_o      = state;

  always_comb begin
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_branch = (opcode == OP_BRANCH);
    is_jal    = (opcode == OP_JAL);
    is_jalr   = (opcode == OP_JALR);
    is_lui    = (opcode == OP_LUI);
    is_auipc  = (opcode == OP_AUIPC);
    is_op     = (opcode == OP_R);
    is_op_imm = (opcode == OP_IMM);
    is_legal  = is_load | is_store | is_branch | is_jal | is_jalr |
                is_lui | is_auipc | is_op | is_op_imm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      instr_o     <= 32'h0000_0013;
      imem_req_o  <= 1'b0;
      dmem_req_o  <= 1'b0;
      dmem_we_o   <= 1'b0;
      imm_type_o  <= IMM_R;
      alu_src_a_o <= 1'b0;
      alu_src_b_o <= 1'b0;
      reg_we_o    <= 1'b0;
      wb_sel_o    <= 2'b00;
      pc_we_o     <= 1'b0;
      pc_src_o    <= 2'b00;
      illegal_o   <= 1'b0;
      bus_err_o   <= 1'b0;
      wait_cnt    <= 16'd0;
    end else begin
      reg_we_o <= 1'b0;
      pc_we_o  <= 1'b0;

      case (state)
        S_FETCH: begin
          if (!imem_req_o) begin
            // Only reached straight out of reset.
            imem_req_o <= 1'b1;
            wait_cnt   <= 16'd0;
          end else if (imem_ack_in) begin
            imem_req_o <= 1'b0;
            instr_o    <= imem_rdata_in;
            state      <= S_DECODE;
          end else if (wait_expired) begin
            imem_req_o <= 1'b0;
            bus_err_o  <= 1'b1;
            state      <= S_TRAP;
          end else begin
            wait_cnt <= wait_next[15:0];
          end
        end

        S_DECODE: begin
          if (!is_legal) begin
            illegal_o <= 1'b1;
            state     <= S_TRAP;
          end else begin
            state       <= S_EXEC;
            alu_src_a_o <= is_auipc;
            alu_src_b_o <= is_op_imm | is_load | is_store | is_auipc;
            if (is_op)                                imm_type_o <= IMM_R;
            else if (is_op_imm | is_load | is_jalr)   imm_type_o <= IMM_I;
            else if (is_store)                        imm_type_o <= IMM_S;
            else if (is_branch)                       imm_type_o <= IMM_B;
            else if (is_lui | is_auipc)               imm_type_o <= IMM_U;
            else                                      imm_type_o <= IMM_J;
            // Control transfers complete in EXEC, so their strobes go up now.
            if (is_branch) begin
              pc_we_o  <= 1'b1;
              pc_src_o <= branch_taken_in ? 2'b01 : 2'b00;
            end else if (is_jal | is_jalr) begin
              reg_we_o <= rd_nonzero;
              wb_sel_o <= 2'b10;
              pc_we_o  <= 1'b1;
              pc_src_o <= is_jal ? 2'b01 : 2'b10;
            end
          end
        end

        S_EXEC: begin
          if (is_branch | is_jal | is_jalr) begin
            state      <= S_FETCH;
            imem_req_o <= 1'b1;
            wait_cnt   <= 16'd0;
          end else if (is_load | is_store) begin
            state      <= S_MEM;
            dmem_req_o <= 1'b1;
            dmem_we_o  <= is_store;
            wait_cnt   <= 16'd0;
          end else begin
            state    <= S_WB;
            reg_we_o <= rd_nonzero;
            pc_we_o  <= 1'b1;
            pc_src_o <= 2'b00;
            wb_sel_o <= is_lui ? 2'b11 : 2'b00;
          end
        end

        S_MEM: begin
          if (dmem_ack_in) begin
            dmem_req_o <= 1'b0;
            dmem_we_o  <= 1'b0;
            pc_we_o    <= 1'b1;
            pc_src_o   <= 2'b00;
            if (is_store) begin
              state      <= S_FETCH;
              imem_req_o <= 1'b1;
              wait_cnt   <= 16'd0;
            end else begin
              state    <= S_WB;
              reg_we_o <= rd_nonzero;
              wb_sel_o <= 2'b01;
            end
          end else if (wait_expired) begin
            dmem_req_o <= 1'b0;
            dmem_we_o  <= 1'b0;
            bus_err_o  <= 1'b1;
            state      <= S_TRAP;
          end else begin
            wait_cnt <= wait_next[15:0];
          end
        end

        S_WB: begin
          state      <= S_FETCH;
          imem_req_o <= 1'b1;
          wait_cnt   <= 16'd0;
        end

        S_TRAP: begin
          state      <= S_TRAP;
          imem_req_o <= 1'b0;
          dmem_req_o <= 1'b0;
          dmem_we_o  <= 1'b0;
        end

        default: begin
          state <= S_TRAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed cases plus random instructions checked
// against a per-instruction timing/control table model.
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_o;
  logic        imem_ack_in = 1'b0;
  logic [31:0] imem_rdata_in = 32'h0;
  logic [31:0] instr_o;
  logic [2:0]  imm_type_o;
  logic        alu_src_a_o;
  logic        alu_src_b_o;
  logic        branch_taken_in = 1'b0;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        dmem_ack_in = 1'b0;
  logic        reg_we_o;
  logic [1:0]  wb_sel_o;
  logic        pc_we_o;
  logic [1:0]  pc_src_o;
  logic        illegal_o;
  logic        bus_err_o;
  logic [2:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.ACK_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_ack_in(imem_ack_in), .imem_rdata_in(imem_rdata_in),
    .instr_o(instr_o), .imm_type_o(imm_type_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .branch_taken_in(branch_taken_in),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_in(dmem_ack_in),
    .reg_we_o(reg_we_o), .wb_sel_o(wb_sel_o),
    .pc_we_o(pc_we_o), .pc_src_o(pc_src_o),
    .illegal_o(illegal_o), .bus_err_o(bus_err_o), .state_o(state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack_in = 1'b0;
    dmem_ack_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("req_after_reset", imem_req_o, 1);
  endtask

  // Wait for the fetch request, ack it after fd extra cycles; ends sampled in DECODE.
  task automatic do_fetch(input logic [31:0] ins, input int fd, output bit ok);
    int waited;
    ok = 1'b0;
    waited = 0;
    while (!imem_req_o && waited < 10) begin
      step();
      waited++;
    end
    for (int c = 0; c <= fd; c++) begin
      if (c > 0) step();
      if (!imem_req_o) begin
        check("fetch_req", imem_req_o, 1);
        return;
      end
    end
    imem_rdata_in = ins;
    imem_ack_in = 1'b1;
    step();
    imem_ack_in = 1'b0;
    imem_rdata_in = $urandom;
    check("instr_latch", instr_o, ins);
    check("decode_state", state_o, 1);
    ok = 1'b1;
  endtask

  // Cycle k = 1 is the fetch-ack cycle. Reference model: expected controls and
  // the cycle in which the PC strobe (and any regfile write) must appear.
  task automatic run_instr(input logic [31:0] ins, input int fd, input int dd, input logic tk);
    bit ok;
    int k, dreq, reg_cnt, reg_cyc, pc_cnt, pc_cyc;
    logic [1:0] wb_seen, src_seen;
    logic [2:0] imm_seen;
    logic a_seen, b_seen, dwe_seen;
    logic [6:0] op;
    int exp_pc_cyc;
    logic [2:0] exp_imm;
    logic [1:0] exp_wb, exp_src;
    logic exp_a, exp_b, exp_reg, is_mem, chk_src;

    op = ins[6:0];
    exp_a = 0; exp_b = 0; exp_wb = 0; exp_src = 0; exp_reg = 0; is_mem = 0; chk_src = 0;
    exp_imm = 0; exp_pc_cyc = 4;
    case (op)
      7'b0110011: begin exp_imm = 0; exp_reg = 1; chk_src = 1; end
      7'b0010011: begin exp_imm = 1; exp_reg = 1; exp_b = 1; chk_src = 1; end
      7'b0110111: begin exp_imm = 4; exp_reg = 1; exp_wb = 3; end
      7'b0010111: begin exp_imm = 4; exp_reg = 1; exp_a = 1; exp_b = 1; chk_src = 1; end
      7'b0000011: begin exp_imm = 1; exp_reg = 1; exp_wb = 1; exp_b = 1; is_mem = 1; chk_src = 1;
                        exp_pc_cyc = 5 + dd; end
      7'b0100011: begin exp_imm = 6; exp_b = 1; is_mem = 1; chk_src = 1; exp_pc_cyc = 5 + dd; end
      7'b1100011: begin exp_imm = 3; exp_src = tk ? 2'b01 : 2'b00; exp_pc_cyc = 3; end
      7'b1101111: begin exp_imm = 5; exp_reg = 1; exp_wb = 2; exp_src = 1; exp_pc_cyc = 3; end
      7'b1100111: begin exp_imm = 1; exp_reg = 1; exp_wb = 2; exp_src = 2; exp_pc_cyc = 3; end
      default: ;
    endcase
    if (ins[11:7] == 5'd0) exp_reg = 0;

    branch_taken_in = tk;
    do_fetch(ins, fd, ok);
    if (!ok) return;
    k = 2; dreq = 0; reg_cnt = 0; reg_cyc = 0; pc_cnt = 0; pc_cyc = 0;
    wb_seen = 0; src_seen = 0; imm_seen = 0; a_seen = 0; b_seen = 0; dwe_seen = 0;
    forever begin
      if (k == 3) begin imm_seen = imm_type_o; a_seen = alu_src_a_o; b_seen = alu_src_b_o; end
      if (dmem_req_o) begin
        dreq++;
        dwe_seen = dmem_we_o;
        if (dreq == dd + 1) dmem_ack_in = 1'b1;
      end
      if (reg_we_o) begin reg_cnt++; reg_cyc = k; wb_seen = wb_sel_o; end
      if (pc_we_o) begin pc_cnt++; pc_cyc = k; src_seen = pc_src_o; end
      if (pc_we_o || k >= 20) break;
      step();
      dmem_ack_in = 1'b0;
      k++;
    end

    check("imm_type", imm_seen, exp_imm);
    check("pc_we_cycle", pc_cyc, exp_pc_cyc);
    check("pc_we_count", pc_cnt, 1);
    check("pc_src", src_seen, exp_src);
    check("reg_we_count", reg_cnt, exp_reg ? 1 : 0);
    if (exp_reg) begin
      check("reg_we_cycle", reg_cyc, exp_pc_cyc);
      check("wb_sel", wb_seen, exp_wb);
    end
    if (chk_src) begin
      check("alu_src_a", a_seen, exp_a);
      check("alu_src_b", b_seen, exp_b);
    end
    check("dmem_req_cycles", dreq, is_mem ? dd + 1 : 0);
    if (is_mem) check("dmem_we", dwe_seen, (op == 7'b0100011) ? 1 : 0);
  endtask

  logic [6:0] ops [9];

  initial begin
    bit ok;
    int n;
    logic [31:0] ins;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};

    #12;
    check("rst_state", state_o, 0);
    check("rst_instr", instr_o, 32'h0000_0013);
    check("rst_req", {imem_req_o, dmem_req_o, reg_we_o, pc_we_o}, 0);
    check("rst_sel", {imm_type_o, alu_src_a_o, alu_src_b_o, wb_sel_o, pc_src_o}, 0);
    check("rst_sticky", {illegal_o, bus_err_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("req_first_cycle", imem_req_o, 1);

    run_instr(32'h00208033, 0, 0, 1'b0);   // ADD
    run_instr(32'h0040A103, 0, 3, 1'b0);   // LW, dmem ack after 3 cycles
    run_instr(32'h00208463, 1, 0, 1'b1);   // BEQ taken
    run_instr(32'h00208463, 0, 0, 1'b0);   // BEQ not taken
    run_instr(32'h00500013, 2, 0, 1'b0);   // ADDI x0: no regfile write
    run_instr(32'h00208033, TIMEOUT - 1, 0, 1'b0);  // ack on the last allowed cycle
    check("no_trap_last_ack", bus_err_o, 0);

    for (int i = 0; i < 40; i++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 5) == 0) ins[11:7] = 5'd0;
      run_instr(ins, $urandom_range(0, TIMEOUT - 1), $urandom_range(0, TIMEOUT - 1),
                1'($urandom_range(0, 1)));
    end
    check("no_sticky_after_random", {illegal_o, bus_err_o}, 0);

    // Reset while a load waits in MEM.
    do_fetch(32'h0040A103, 0, ok);
    step();
    step();
    check("mem_req_before_rst", dmem_req_o, 1);
    rst_n = 1'b0;
    #1;
    check("mem_req_dropped", dmem_req_o, 0);
    check("mem_rst_state", state_o, 0);
    do_reset();
    check("fetch_after_rst", state_o, 0);

    // Illegal opcode traps and stays quiet.
    do_fetch(32'h0000007F, 0, ok);
    step();
    check("illegal_state", state_o, 5);
    check("illegal_flag", illegal_o, 1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      imem_ack_in = 1'($urandom_range(0, 1));
      dmem_ack_in = 1'($urandom_range(0, 1));
      step();
      if (imem_req_o || dmem_req_o || reg_we_o || pc_we_o) n++;
    end
    imem_ack_in = 1'b0;
    dmem_ack_in = 1'b0;
    check("trap_quiet", n, 0);
    check("trap_stays", state_o, 5);

    // Fetch timeout with no ack.
    do_reset();
    n = 0;
    while (imem_req_o && n < 20) begin
      n++;
      step();
    end
    check("timeout_req_cycles", n, TIMEOUT);
    check("timeout_bus_err", bus_err_o, 1);
    check("timeout_state", state_o, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
